// File: rtl/vend_coin_sched.sv
// Coin scheduler and dispense sequencer in front of the vending FSM core.
// Optional statistics counters are built only when VEND_SCHED_STATS_EN is defined.
module vend_coin_sched #(
  parameter int NUM_SLOTS    = 3,
  parameter int DISP_TIMEOUT = 15,
  parameter int CNT_W        = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SLOTS-1:0]   slot_req,
  input  logic [2*NUM_SLOTS-1:0] slot_coin,
  output logic [NUM_SLOTS-1:0]   slot_ack,
  output logic [1:0]             grant_id,
  output logic [1:0]             coin_out,
  input  logic                   prod_in,
  input  logic                   chg_in,
  output logic                   disp_req,
  input  logic                   disp_done,
  output logic                   chg_req,
  input  logic                   chg_done,
  input  logic                   fault_clr,
  output logic                   busy,
  output logic                   fault,
  output logic [CNT_W-1:0]       vend_cnt,
  output logic [CNT_W-1:0]       chg_cnt
);
  localparam int               TMR_W     = (DISP_TIMEOUT > 1) ? $clog2(DISP_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(DISP_TIMEOUT - 1);
  localparam logic [2:0]       SLOTS3    = 3'(NUM_SLOTS);
  localparam logic [1:0]       SLOT_LAST = 2'(NUM_SLOTS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FAULT} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [1:0]             r_ptr;
  logic [1:0]             r_grant_id;
  logic [NUM_SLOTS-1:0]   r_slot_ack;
  logic [1:0]             r_coin_out;
  logic                   r_disp_req;
  logic                   r_chg_req;
  logic [TMR_W-1:0]       r_timer;

  logic [3:0]             w_elig;
  logic                   w_found;
  logic [1:0]             w_gnt_idx;
  logic [2:0]             w_scan;
  logic [1:0]             w_gnt_coin;
  logic [NUM_SLOTS-1:0]   w_gnt_onehot;
  logic [1:0]             w_ptr_adv;
  logic                   w_disp_keep;
  logic                   w_chg_keep;
  logic                   w_tmo;

  logic [NUM_SLOTS-1:0]   w_ack_nxt;
  logic [1:0]             w_coin_nxt;
  logic [1:0]             w_gid_nxt;
  logic [1:0]             w_ptr_nxt;
  logic                   w_disp_nxt;
  logic                   w_chg_nxt;
  logic [TMR_W-1:0]       w_timer_nxt;

  // A slot with a pending request but coin code 00 is never eligible.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_elig[i] = slot_req[i] && (slot_coin[2*i +: 2] != 2'b00);
    end
  end

  // Round-robin search starting at r_ptr, the slot after the last grant.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = 2'd0;
    w_scan    = 3'd0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      w_scan = {1'b0, r_ptr} + 3'(k);
      if (w_scan >= SLOTS3) begin
        w_scan = w_scan - SLOTS3;
      end
      if (!w_found && w_elig[w_scan[1:0]]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_scan[1:0];
      end
    end
  end

  always_comb begin
    w_gnt_coin   = 2'b00;
    w_gnt_onehot = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (w_gnt_idx == 2'(i)) begin
        w_gnt_coin      = slot_coin[2*i +: 2];
        w_gnt_onehot[i] = 1'b1;
      end
    end
  end

  assign w_ptr_adv   = (w_gnt_idx == SLOT_LAST) ? 2'd0 : w_gnt_idx + 2'd1;
  assign w_disp_keep = r_disp_req && !disp_done;
  assign w_chg_keep  = r_chg_req && !chg_done;
  assign w_tmo       = (r_timer == TMR_LAST);

  // ---- state register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = prod_in ? S_WAIT : S_IDLE;
      S_WAIT: begin
        // Completion wins over a timeout landing on the same edge.
        if (!w_disp_keep && !w_chg_keep) begin
          w_state_nxt = S_IDLE;
        end else if (w_tmo) begin
          w_state_nxt = S_FAULT;
        end
      end
      S_FAULT: if (fault_clr) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---- output logic (next values of the registered outputs) ----
  always_comb begin
    w_ack_nxt   = '0;
    w_coin_nxt  = 2'b00;
    w_gid_nxt   = r_grant_id;
    w_ptr_nxt   = r_ptr;
    w_disp_nxt  = 1'b0;
    w_chg_nxt   = 1'b0;
    w_timer_nxt = '0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_ack_nxt  = w_gnt_onehot;
          w_coin_nxt = w_gnt_coin;
          w_gid_nxt  = w_gnt_idx;
          w_ptr_nxt  = w_ptr_adv;
        end
      end
      S_ISSUE: begin
        if (prod_in) begin
          w_disp_nxt = 1'b1;
          w_chg_nxt  = chg_in;
        end
      end
      S_WAIT: begin
        if (w_state_nxt == S_WAIT) begin
          w_disp_nxt  = w_disp_keep;
          w_chg_nxt   = w_chg_keep;
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end
      default: begin
      end
    endcase
  end

  // ---- output registers ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot_ack <= '0;
      r_coin_out <= 2'b00;
      r_grant_id <= 2'd0;
      r_ptr      <= 2'd0;
      r_disp_req <= 1'b0;
      r_chg_req  <= 1'b0;
      r_timer    <= '0;
    end else begin
      r_slot_ack <= w_ack_nxt;
      r_coin_out <= w_coin_nxt;
      r_grant_id <= w_gid_nxt;
      r_ptr      <= w_ptr_nxt;
      r_disp_req <= w_disp_nxt;
      r_chg_req  <= w_chg_nxt;
      r_timer    <= w_timer_nxt;
    end
  end

  assign slot_ack = r_slot_ack;
  assign grant_id = r_grant_id;
  assign coin_out = r_coin_out;
  assign disp_req = r_disp_req;
  assign chg_req  = r_chg_req;
  assign busy     = (r_state != S_IDLE);
  assign fault    = (r_state == S_FAULT);

`ifdef VEND_SCHED_STATS_EN
  logic [CNT_W-1:0] r_vend_cnt;
  logic [CNT_W-1:0] r_chg_cnt;
  logic             w_vend_inc;
  logic             w_chg_inc;

  assign w_vend_inc = (r_state == S_ISSUE) && prod_in;
  assign w_chg_inc  = w_vend_inc && chg_in;

  // Saturating event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vend_cnt <= '0;
      r_chg_cnt  <= '0;
    end else begin
      if (w_vend_inc && (r_vend_cnt != '1)) r_vend_cnt <= r_vend_cnt + CNT_W'(1);
      if (w_chg_inc && (r_chg_cnt != '1))   r_chg_cnt  <= r_chg_cnt + CNT_W'(1);
    end
  end

  assign vend_cnt = r_vend_cnt;
  assign chg_cnt  = r_chg_cnt;
`else
  assign vend_cnt = '0;
  assign chg_cnt  = '0;
`endif

endmodule
